rib_arbiter: RTL and testbench
==============================

// Module: rib_arbiter
// PURPOSE
//  Registered arbiter/sequencer for the RIB bus: picks one of 4 masters, holds the grant until the slave acks.
//  Replaces fixed-priority combinational grant with round-robin plus optional absolute-priority master.
//  Adds a per-transfer timeout so a hung slave cannot lock the bus.
//  Drives the bus mux select (grant_o) and per-master stall flags.
// PARAMETERS
//  NUM_M    4   number of masters (grant width = clog2(NUM_M))
//  HP_EN    1   1: master HP_ID wins every arbitration it requests; 0: pure round-robin
//  HP_ID    3   absolute-priority master index (used only when HP_EN=1)
//  TIMEOUT  16  max BUSY cycles without ack before forced release (>=2)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous reset, active-low
//  req_i        in   NUM_M  per-master access request, held until the master sees hold_o drop
//  ack_i        in   1      selected slave completes current transfer this cycle
//  grant_o      out  2      index of granted master (bus mux select)
//  grant_vld_o  out  1      grant_o valid / bus owned
//  hold_o       out  NUM_M  per-master stall: request pending and not yet acked
//  timeout_o    out  1      one-cycle pulse: transfer aborted by timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, grant_o=0, grant_vld_o=0, timeout_o=0, cnt=0, last=NUM_M-1.
//  States: IDLE (no owner), BUSY (owner = grant_o).
//  Winner function W(req): if HP_EN and req[HP_ID] -> HP_ID; else first set bit scanning
//   last+1, last+2, ... wrapping modulo NUM_M (last itself is checked last).
//  IDLE: req_i!=0 -> at next edge grant_o=W(req_i), grant_vld_o=1, cnt=0, -> BUSY. Latency 1 cycle.
//   req_i=0 -> stay IDLE, outputs unchanged except grant_vld_o=0.
//  BUSY, end-of-transfer when any of:
//   (a) ack_i=1; (b) req_i[grant_o]=0 (master withdrew); (c) cnt==TIMEOUT-1 and ack_i=0.
//   On end: last<=grant_o; cnt<=0; if req' != 0 re-arbitrate same edge (back-to-back, no idle bubble),
//   else grant_vld_o<=0, -> IDLE. req' = req_i with bit grant_o cleared when (a) fires in the same cycle.
//   (c) only: timeout_o<=1 for exactly one cycle; timed-out master's req bit masked from the same-edge re-arbitration.
//  BUSY, no end condition: cnt<=cnt+1, grant held stable.
//  Priority of end causes: ack beats timeout (ack_i=1 on cnt==TIMEOUT-1 -> normal completion, no pulse).
//  hold_o[i] (combinational) = req_i[i] & ~(grant_vld_o & grant_o==i & ack_i).
//  cnt width = clog2(TIMEOUT); never wraps (reset on end / grant).
//  grant_o changes only on a clock edge; glitch-free for slave select decode.
//  Reset asserted mid-transfer: immediate return to reset values; in-flight transfer dropped, no timeout pulse.
// TESTING
//  1 Reset, req_i=0001, ack_i next cycle -> grant_o=0, grant_vld_o=1 one cycle after req; hold_o[0]=0 on ack cycle.
//  2 req_i=0111 held, ack every BUSY cycle, HP_EN=0 -> grant sequence 0,1,2,0,1,2 back-to-back, grant_vld_o never drops.
//  3 HP_EN=1, req_i=0011 busy on master 0, assert req_i[3] -> after ack grant_o=3, then 1 (round-robin resumes after 0).
//  4 Grant master 2, ack_i=0 for 16 cycles -> timeout_o pulses on cycle 16, grant moves to next requester, master 2 skipped that edge.
//  5 ack_i=1 exactly on cycle cnt=15 -> normal completion, timeout_o stays 0.
//  6 Granted master drops req mid-BUSY -> release next edge; rst low mid-BUSY -> grant_vld_o=0, timeout_o=0 immediately.

Source files
------------

// File: rtl/rib_arbiter.sv
// Purpose     : RIB bus arbiter. Picks one of NUM_M masters (round-robin, with an optional
//               absolute-priority master), holds the grant until ack, and aborts hung transfers.
// Latency     : grant 1 cycle after request; back-to-back re-arbitration on the ending edge.
// Backpressure: hold[i] stalls master i until its transfer is acked. A timeout frees the bus.
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   req_i[NUM_M]     per-master request, held until the master sees hold_o drop
//   ack_i            selected slave completes the current transfer this cycle
//   grant_o          registered index of the bus owner (mux select)
//   grant_vld_o      bus owned / grant_o valid
//   hold_o[NUM_M]    per-master stall (combinational)
//   timeout_o        one-cycle pulse when a transfer is aborted by timeout
module rib_arbiter #(
  parameter int NUM_M   = 4,
  parameter int HP_EN   = 1,
  parameter int HP_ID   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         req_i,
  input  logic                     ack_i,
  output logic [$clog2(NUM_M)-1:0] grant_o,
  output logic                     grant_vld_o,
  output logic [NUM_M-1:0]         hold_o,
  output logic                     timeout_o
);

  localparam int GW = $clog2(NUM_M);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state;
  logic [GW-1:0]   last;
  logic [CW-1:0]   cnt;

  // Round-robin scan starts just after the previous owner, so that owner is
  // checked last. The priority master overrides the scan whenever it requests.
  function automatic logic [GW-1:0] pick(input logic [NUM_M-1:0] r,
                                         input logic [GW-1:0]    lst);
    logic [GW-1:0] w;
    logic          found;
    int            idx;
    w     = lst;
    found = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = (int'(lst) + k) % NUM_M;
      if (!found && r[idx]) begin
        w     = GW'(idx);
        found = 1'b1;
      end
    end
    if (HP_EN != 0 && r[HP_ID]) w = GW'(HP_ID);
    return w;
  endfunction

  logic [NUM_M-1:0] owner_oh;
  logic [NUM_M-1:0] req_rest;
  logic             to_hit;
  logic             xfer_end;
  logic [GW-1:0]    win_idle;
  logic [GW-1:0]    win_busy;

  always_comb begin
    owner_oh = NUM_M'(1) << grant_o;
    // Ack wins over timeout: a transfer acked on its last allowed cycle is a normal completion.
    to_hit   = (cnt == CW'(TIMEOUT - 1)) && !ack_i;
    xfer_end = ack_i || !req_i[grant_o] || to_hit;
    // The ending owner is excluded from the same-edge re-arbitration: either it was just
    // served (ack), it has withdrawn (bit already 0), or it timed out and must yield.
    req_rest = req_i & ~owner_oh;
    win_idle = pick(req_i, last);
    win_busy = pick(req_rest, grant_o);
    hold_o   = req_i & ~({NUM_M{grant_vld_o & ack_i}} & owner_oh);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant_o     <= '0;
      grant_vld_o <= 1'b0;
      timeout_o   <= 1'b0;
      cnt         <= '0;
      last        <= GW'(NUM_M - 1);
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            grant_o     <= win_idle;
            grant_vld_o <= 1'b1;
            cnt         <= '0;
            state       <= BUSY;
          end else begin
            grant_vld_o <= 1'b0;
          end
        end
        BUSY: begin
          if (xfer_end) begin
            last      <= grant_o;
            cnt       <= '0;
            timeout_o <= to_hit;
            if (|req_rest) begin
              grant_o <= win_busy;
            end else begin
              grant_vld_o <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (timeout, ack on the last cycle, async reset).
module tb_rib_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic       ack_i;
  logic [1:0] grant_o;
  logic       grant_vld_o;
  logic [3:0] hold_o;
  logic       timeout_o;

  int total;
  int bad;

  rib_arbiter #(.NUM_M(4), .HP_EN(1), .HP_ID(3), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .ack_i       (ack_i),
    .grant_o     (grant_o),
    .grant_vld_o (grant_vld_o),
    .hold_o      (hold_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [3:0] hold;   // combinational, before the edge
    logic [1:0] gnt;    // registered, after the edge
    logic       vld;
    logic       to;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic a);
    req_i = r;
    ack_i = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] g, input logic v, input logic t);
    chk({tag, " grant"}, 32'(grant_o), 32'(g));
    chk({tag, " vld"}, 32'(grant_vld_o), 32'(v));
    chk({tag, " timeout"}, 32'(timeout_o), 32'(t));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    req_i = '0;
    ack_i = 1'b0;

    // rst_n, req, ack, hold, grant, vld, timeout
    // single master, ack on first BUSY cycle
    vecs[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    // round-robin 0,1,2,0,1,2 back-to-back, then withdrawal of owner 2
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0111, 1'b0, 4'b0111, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'b0111, 1'b1, 4'b0110, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'b0111, 1'b1, 4'b0101, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b0111, 1'b1, 4'b0011, 2'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'b0111, 1'b1, 4'b0110, 2'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'b0111, 1'b1, 4'b0101, 2'd2, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
    // priority master 3 preempts the round-robin choice, then rotation resumes after 0
    vecs[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'b0011, 1'b0, 4'b0011, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 4'b1011, 1'b0, 4'b1011, 2'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 4'b1011, 1'b1, 4'b1010, 2'd3, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};

    @(posedge clk);
    #1;
    chk("reset grant", 32'(grant_o), 32'd0);
    chk("reset vld", 32'(grant_vld_o), 32'd0);
    chk("reset timeout", 32'(timeout_o), 32'd0);

    for (int i = 0; i < 19; i++) begin
      rst   = vecs[i].rst_n;
      req_i = vecs[i].req;
      ack_i = vecs[i].ack;
      #1;
      chk($sformatf("v%0d hold", i), 32'(hold_o), 32'(vecs[i].hold));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].gnt, vecs[i].vld, vecs[i].to);
    end

    // Timeout with another requester waiting; then async reset during the pulse.
    rst = 1'b0;
    step(4'b0000, 1'b0);
    rst = 1'b1;
    step(4'b0100, 1'b0);
    chk_out("to_a grant", 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(4'b0110, 1'b0);
    chk_out("to_a cnt15", 2'd2, 1'b1, 1'b0);
    chk("to_a hold", 32'(hold_o), 32'b0110);
    step(4'b0110, 1'b0);
    chk_out("to_a expire", 2'd1, 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    chk_out("to_a async rst", 2'd0, 1'b0, 1'b0);
    step(4'b0000, 1'b0);
    rst = 1'b1;

    // Timeout with the hung master alone: it is masked, bus idles one cycle, then regranted.
    step(4'b0100, 1'b0);
    chk_out("to_b grant", 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk_out("to_b expire", 2'd2, 1'b0, 1'b1);
    step(4'b0100, 1'b0);
    chk_out("to_b regrant", 2'd2, 1'b1, 1'b0);

    // Ack on the final allowed cycle is a normal completion.
    rst = 1'b0;
    step(4'b0000, 1'b0);
    rst = 1'b1;
    step(4'b0100, 1'b0);
    for (int i = 0; i < 15; i++) step(4'b0110, 1'b0);
    chk_out("ack15 pre", 2'd2, 1'b1, 1'b0);
    step(4'b0110, 1'b1);
    chk_out("ack15 done", 2'd1, 1'b1, 1'b0);
    step(4'b0010, 1'b0);
    chk_out("ack15 after", 2'd1, 1'b1, 1'b0);

    // Owner withdraws mid-transfer, then async reset while busy on a nonzero grant.
    step(4'b0000, 1'b0);
    chk_out("withdraw", 2'd1, 1'b0, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk_out("busy2", 2'd2, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk_out("mid rst", 2'd0, 1'b0, 1'b0);
    step(4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
